seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller for the sc_computer I/O subsystem.
- Displays a NUM_DIGITS-digit hex value on two segment buses that share one digit-select bus.
- Each scan step drives one digit from the lower half and one from the upper half.
- A double-buffered value register means a new value only takes effect at a frame boundary, so the display never tears.
- Supports per-digit decimal points, leading-zero blanking, and a display enable.

Parameters:
NUM_DIGITS, 8, total digits; even, 2..16; H = NUM_DIGITS/2 digits per bus
DIV, 16, sys_clk_in cycles per scan step; >=2

Ports:
sys_clk_in  in  1  system clock, rising edge
sys_rst  in  1  synchronous reset, active-high
en  in  1  display enable; 0 = dark and scan frozen
load  in  1  one-cycle strobe; capture value_in/dp_in into pending register
value_in  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i (digit 0 = rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  in  1  1 = blank leading zero digits
seg_data_0_pin  out  8  segments for lower-half digit; index 0..7 = A,B,C,D,E,F,G,DP; active-high
seg_data_1_pin  out  8  segments for upper-half digit; same encoding
seg_cs_pin  out  NUM_DIGITS  digit select, active-high, exactly two bits set while lit
frame_done  out  1  one-cycle pulse when the scan wraps from step H-1 to step 0

Behaviour:
- Reset: synchronous, active-high; overrides all other inputs, including mid-frame.
  - Reset values: seg_cs_pin=0, seg_data_0_pin=0, seg_data_1_pin=0, frame_done=0.
  - Also cleared: prescaler=0, step=0, active value=0, active dp=0, pending=0, pend_valid=0.
- Prescaler: counts 0..DIV-1 while en=1; tick = (prescaler==DIV-1); holds its value while en=0.
- Step counter: 0..H-1.
  - Advances on tick.
  - Wraps H-1 -> 0; at the wrap tick frame_done=1 for exactly one cycle.
- Pending register:
  - load=1 captures value_in and dp_in into pending and sets pend_valid.
  - A later load before the next wrap overwrites pending (last load wins).
- Active register: updated only on the wrap tick, and only if pend_valid (active<=pending, pend_valid<=0).
  - If load coincides with the wrap tick, value_in/dp_in go straight into active (bypass) and pend_valid ends at 0.
- Outputs: registered; they reflect step/active one cycle later.
  - When en=1: seg_cs_pin bit s and bit s+H = 1 (s = current step).
  - seg_data_0_pin shows digit s; seg_data_1_pin shows digit s+H.
  - When en=0: seg_cs_pin=0, both segment buses = 0 on the next cycle.
- Hex font, bits A..G: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - DP bit = active dp for that digit.
- Leading-zero blanking, when blank_lz=1:
  - Digit i (i>=1) has A..G forced to 0 if it and every higher digit are zero nibbles.
  - Digit 0 is never blanked.
  - DP is unaffected by blanking.
  - blank_lz is applied combinationally on the active value, so it takes effect at the next output register update with no frame wait.

Test Plan (NUM_DIGITS=8, DIV=4, frame = 16 cycles):
1. Assert sys_rst for 3 cycles mid-scan -> all outputs 0 the cycle after the first reset edge; after release with en=1, seg_cs_pin=00010001 and seg_data_0_pin=seg_data_1_pin=1111110_0 (value 0).
2. load 0x76543210, dp_in=0x00, blank_lz=0; wait for wrap -> steps 0..3 give cs 00010001/00100010/01000100/10001000 with seg0/seg1 = digits 0/4, 1/5, 2/6, 3/7; each step lasts 4 cycles; frame_done pulses every 16 cycles.
3. load 0x000000A5 mid-frame (step 1) -> outputs keep the old value until the wrap; after the wrap, step 0 shows seg0=1011011_0 (5) and seg1=1111110_0 (0).
4. Active value 0x00000050, dp_in=0x04, blank_lz=1 -> digits 7..2 have A..G=0000000; digit 2 DP=1; digit 1 = 1011011 (5); digit 0 = 1111110 (0). Value 0x0, blank_lz=1 -> only digit 0 shows 1111110.
5. load coincident with the wrap tick, value 0x11111111 -> the frame starting next shows 0110000 on every digit immediately; pend_valid=0, so the following wrap changes nothing.
6. en=0 for 10 cycles during step 2 -> seg_cs_pin=0 and both buses=0 from the next cycle; on en=1, scan resumes at step 2 with the prescaler value it held.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: two segment buses share one digit-select bus,
// with a double-buffered value so a new value only appears at a frame boundary.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 16
) (
  input  logic                    sys_clk_in,
  input  logic                    sys_rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [7:0]              seg_data_0_pin,
  output logic [7:0]              seg_data_1_pin,
  output logic [NUM_DIGITS-1:0]   seg_cs_pin,
  output logic                    frame_done
);

  localparam int H  = NUM_DIGITS / 2;
  localparam int PW = $clog2(DIV);
  localparam int SW = (H > 1) ? $clog2(H) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(H - 1);

  logic [PW-1:0]             presc_reg;
  logic [SW-1:0]             step_reg;
  logic [4*NUM_DIGITS-1:0]   active_reg;
  logic [NUM_DIGITS-1:0]     active_dp_reg;
  logic [4*NUM_DIGITS-1:0]   pending_reg;
  logic [NUM_DIGITS-1:0]     pending_dp_reg;
  logic                      pend_valid_reg;

  logic                      tick;
  logic                      wrap;
  logic [IW-1:0]             lo_idx;
  logic [IW-1:0]             hi_idx;
  logic [7:0]                digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     cs_next;
  logic [7:0]                seg0_next;
  logic [7:0]                seg1_next;

  // Returns segments with bit 0 = A ... bit 6 = G.
  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] abcdefg;
    logic [6:0] res;
    case (nib)
      4'h0: abcdefg = 7'b1111110;
      4'h1: abcdefg = 7'b0110000;
      4'h2: abcdefg = 7'b1101101;
      4'h3: abcdefg = 7'b1111001;
      4'h4: abcdefg = 7'b0110011;
      4'h5: abcdefg = 7'b1011011;
      4'h6: abcdefg = 7'b1011111;
      4'h7: abcdefg = 7'b1110000;
      4'h8: abcdefg = 7'b1111111;
      4'h9: abcdefg = 7'b1111011;
      4'hA: abcdefg = 7'b1110111;
      4'hB: abcdefg = 7'b0011111;
      4'hC: abcdefg = 7'b1001110;
      4'hD: abcdefg = 7'b0111101;
      4'hE: abcdefg = 7'b1001111;
      default: abcdefg = 7'b1000111;
    endcase
    for (int k = 0; k < 7; k++) res[k] = abcdefg[6-k];
    return res;
  endfunction

  assign tick   = en && (presc_reg == PRESC_LAST);
  assign wrap   = tick && (step_reg == STEP_LAST);
  assign lo_idx = IW'(step_reg);
  assign hi_idx = IW'(step_reg) + IW'(H);

  // zero_from[i]: digit i and every digit above it hold zero nibbles.
  generate
    if (NUM_DIGITS > 1) begin : g_lz
      logic [NUM_DIGITS-1:1] zero_from;
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_chain
        if (gi == NUM_DIGITS - 1) begin : g_top
          assign zero_from[gi] = (active_reg[4*gi +: 4] == 4'h0);
        end else begin : g_mid
          assign zero_from[gi] = (active_reg[4*gi +: 4] == 4'h0) && zero_from[gi+1];
        end
        assign digit_seg[gi] = {active_dp_reg[gi],
                                (blank_lz && zero_from[gi]) ? 7'b0 : font(active_reg[4*gi +: 4])};
      end
    end
  endgenerate

  assign digit_seg[0] = {active_dp_reg[0], font(active_reg[3:0])};

  always_comb begin
    cs_next   = '0;
    seg0_next = '0;
    seg1_next = '0;
    if (en) begin
      cs_next[lo_idx] = 1'b1;
      cs_next[hi_idx] = 1'b1;
      seg0_next       = digit_seg[lo_idx];
      seg1_next       = digit_seg[hi_idx];
    end
  end

  always_ff @(posedge sys_clk_in) begin
    if (sys_rst) begin
      presc_reg      <= '0;
      step_reg       <= '0;
      active_reg     <= '0;
      active_dp_reg  <= '0;
      pending_reg    <= '0;
      pending_dp_reg <= '0;
      pend_valid_reg <= 1'b0;
      frame_done     <= 1'b0;
      seg_cs_pin     <= '0;
      seg_data_0_pin <= '0;
      seg_data_1_pin <= '0;
    end else begin
      if (en) presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick) step_reg <= wrap ? '0 : step_reg + 1'b1;
      if (load) begin
        pending_reg    <= value_in;
        pending_dp_reg <= dp_in;
        pend_valid_reg <= 1'b1;
      end
      // A load landing on the wrap bypasses pending so it is not shown a frame late.
      if (wrap) begin
        if (load) begin
          active_reg     <= value_in;
          active_dp_reg  <= dp_in;
          pend_valid_reg <= 1'b0;
        end else if (pend_valid_reg) begin
          active_reg     <= pending_reg;
          active_dp_reg  <= pending_dp_reg;
          pend_valid_reg <= 1'b0;
        end
      end
      frame_done     <= wrap;
      seg_cs_pin     <= cs_next;
      seg_data_0_pin <= seg0_next;
      seg_data_1_pin <= seg1_next;
    end
  end

endmodule
